pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Pipeline control unit for the five-stage Y86-64 core (Fetch/Decode/Execute/Memory/Writeback).
- Generates per-stage stall and bubble controls from load/use, mispredicted-branch and ret hazards.
- Gates the condition-code update in Execute.
- Runs a halt state machine that freezes the pipeline once a non-AOK status reaches Writeback.
- Keeps saturating performance counters for cycles, stalls and bubbles.

Parameters:
CNT_W, 32, width of each performance counter
SAOK, 4'd1, status code: normal operation
SHLT, 4'd2, status code: halt instruction
SADR, 4'd3, status code: bad address
SINS, 4'd4, status code: invalid instruction

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  reset, asynchronous, active-high
D_icode  in  4  icode in Decode register
d_srcA  in  4  decoded source A register id (4'hF = none)
d_srcB  in  4  decoded source B register id (4'hF = none)
E_icode  in  4  icode in Execute register
E_dstM  in  4  memory-destination register id in Execute
e_cnd  in  1  condition result computed in Execute
M_icode  in  4  icode in Memory register
m_stat  in  4  status leaving Memory stage
W_stat  in  4  status in Writeback register
F_stall  out  1  hold PC/Fetch register
D_stall  out  1  hold Decode register
D_bubble  out  1  load nop into Decode register
E_bubble  out  1  load nop into Execute register
M_bubble  out  1  load nop into Memory register
W_stall  out  1  hold Writeback register
set_cc  out  1  allow CC write this cycle
halted  out  1  pipeline frozen (registered)
halt_code  out  4  status that caused halt (registered)
cycle_cnt  out  CNT_W  cycles since reset in RUN
stall_cnt  out  CNT_W  cycles with F_stall=1 in RUN
bubble_cnt  out  CNT_W  cycles with E_bubble=1 in RUN

Behaviour:
- Icodes used: MRMOVQ=5, OPQ=6, JXX=7, RET=9, POPQ=11. Register id 4'hF means "none".
- Hazard terms (combinational):
  - load_use = E_icode in {5, 11} && E_dstM != F && (E_dstM == d_srcA || E_dstM == d_srcB).
  - mispredict = E_icode == 7 && !e_cnd.
  - ret_pend = RET present in D_icode, E_icode or M_icode.
- Outputs in RUN state (combinational):
  - F_stall = load_use || ret_pend.
  - D_stall = load_use.
  - D_bubble = mispredict || (ret_pend && !load_use).
  - E_bubble = mispredict || load_use.
  - M_bubble = (m_stat != SAOK) || (W_stat != SAOK).
  - W_stall = (W_stat != SAOK).
  - set_cc = E_icode == 6 && m_stat == SAOK && W_stat == SAOK.
- Simultaneous load_use and ret_pend: stall Decode, do not bubble it (D_stall=1, D_bubble=0, E_bubble=1).
- Simultaneous mispredict and ret in Decode: mispredict wins. D_bubble=1, E_bubble=1, F_stall=1 for that cycle only.
- D_stall and D_bubble are never both 1.
- State machine (registered):
  - RUN -> HALTED on a rising edge where W_stat != SAOK. halt_code is captured from W_stat on that edge.
  - HALTED is terminal until rst.
- In HALTED:
  - F_stall=1, D_stall=1, D_bubble=0, E_bubble=1, M_bubble=1, W_stall=1, set_cc=0, halted=1.
  - Counters are frozen.
- Counters: update on each rising edge in RUN and saturate at all-ones (no wrap). stall_cnt counts F_stall; bubble_cnt counts E_bubble.
- Reset (asserted at any time, including mid-halt):
  - Immediately: state=RUN, halted=0, halt_code=SAOK, all counters 0.
  - While rst=1, combinational outputs are forced to F_stall=0, D_stall=0, W_stall=0, set_cc=0, D_bubble=E_bubble=M_bubble=1, flushing the pipeline.
  - First RUN evaluation occurs in the cycle after rst deasserts.
- Latency: hazard outputs are same-cycle combinational. halted asserts one edge after the non-AOK W_stat is sampled.

Test Plan:
- Load/use: E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0 for one cycle; stall_cnt +1, bubble_cnt +1.
- Mispredict: E_icode=7, e_cnd=0 -> D_bubble=1, E_bubble=1, F_stall=0. Repeat with e_cnd=1 -> all controls 0.
- Ret sequence: RET walks through D, E, M over 3 cycles -> F_stall=1 and D_bubble=1 for exactly 3 cycles. Add load_use in cycle 1 -> D_stall=1, D_bubble=0 in that cycle.
- Halt: m_stat=SADR for one cycle -> M_bubble=1, set_cc=0 with E_icode=6. Next cycle W_stat=SADR -> after the edge halted=1, halt_code=3, all freeze values held, counters frozen.
- Reset mid-halt: assert rst asynchronously while halted=1 -> halted=0, halt_code=1, counters 0 without a clock edge; bubbles forced to 1 while rst is high.
- Saturation: with CNT_W=4, run 20 cycles with continuous load_use -> cycle_cnt, stall_cnt and bubble_cnt each hold at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// ============================================================================
//  Module      : pipe_hazard_ctrl_if
//  Description : Hazard-unit bundle between the Y86-64 pipeline datapath and
//                its control unit.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface pipe_hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [3:0]       D_icode;
   logic [3:0]       d_srcA;
   logic [3:0]       d_srcB;
   logic [3:0]       E_icode;
   logic [3:0]       E_dstM;
   logic             e_cnd;
   logic [3:0]       M_icode;
   logic [3:0]       m_stat;
   logic [3:0]       W_stat;

   logic             F_stall;
   logic             D_stall;
   logic             D_bubble;
   logic             E_bubble;
   logic             M_bubble;
   logic             W_stall;
   logic             set_cc;
   logic             halted;
   logic [3:0]       halt_code;
   logic [CNT_W-1:0] cycle_cnt;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] bubble_cnt;

   modport master (
      output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_cnd, M_icode, m_stat, W_stat,
      input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc,
      input  halted, halt_code, cycle_cnt, stall_cnt, bubble_cnt
   );

   modport slave (
      input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_cnd, M_icode, m_stat, W_stat,
      output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc,
      output halted, halt_code, cycle_cnt, stall_cnt, bubble_cnt
   );
endinterface

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Y86-64 pipeline stall/bubble control, halt FSM and
//                saturating performance counters.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
   parameter int         CNT_W = 32,
   parameter logic [3:0] SAOK  = 4'd1,
   parameter logic [3:0] SHLT  = 4'd2,
   parameter logic [3:0] SADR  = 4'd3,
   parameter logic [3:0] SINS  = 4'd4
) (
   input  wire logic              clk,
   input  wire logic              rst,
   pipe_hazard_ctrl_if.slave      bus
);

   localparam logic [3:0] I_MRMOVQ = 4'd5;
   localparam logic [3:0] I_OPQ    = 4'd6;
   localparam logic [3:0] I_JXX    = 4'd7;
   localparam logic [3:0] I_RET    = 4'd9;
   localparam logic [3:0] I_POPQ   = 4'd11;
   localparam logic [3:0] R_NONE   = 4'hF;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [0:0] {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       halt_code_q, halt_code_d;
   logic [CNT_W-1:0] cycle_q, cycle_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] bubble_q, bubble_d;

   logic w_load_use, w_mispredict, w_ret_pend;
   logic w_f_stall, w_d_stall, w_d_bubble, w_e_bubble, w_m_bubble, w_w_stall, w_set_cc;

   assign w_load_use   = ((bus.E_icode == I_MRMOVQ) || (bus.E_icode == I_POPQ)) &&
                         (bus.E_dstM != R_NONE) &&
                         ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
   assign w_mispredict = (bus.E_icode == I_JXX) && !bus.e_cnd;
   assign w_ret_pend   = (bus.D_icode == I_RET) || (bus.E_icode == I_RET) ||
                         (bus.M_icode == I_RET);

   // Reset flushes the pipe, HALTED freezes it; otherwise hazard rules apply.
   always_comb begin
      w_f_stall  = w_load_use || w_ret_pend;
      w_d_stall  = w_load_use;
      w_d_bubble = w_mispredict || (w_ret_pend && !w_load_use);
      w_e_bubble = w_mispredict || w_load_use;
      w_m_bubble = (bus.m_stat != SAOK) || (bus.W_stat != SAOK);
      w_w_stall  = (bus.W_stat != SAOK);
      w_set_cc   = (bus.E_icode == I_OPQ) && (bus.m_stat == SAOK) && (bus.W_stat == SAOK);
      if (rst) begin
         w_f_stall  = 1'b0;
         w_d_stall  = 1'b0;
         w_d_bubble = 1'b1;
         w_e_bubble = 1'b1;
         w_m_bubble = 1'b1;
         w_w_stall  = 1'b0;
         w_set_cc   = 1'b0;
      end else if (state_q == ST_HALTED) begin
         w_f_stall  = 1'b1;
         w_d_stall  = 1'b1;
         w_d_bubble = 1'b0;
         w_e_bubble = 1'b1;
         w_m_bubble = 1'b1;
         w_w_stall  = 1'b1;
         w_set_cc   = 1'b0;
      end
   end

   always_comb begin
      state_d     = state_q;
      halt_code_d = halt_code_q;
      cycle_d     = cycle_q;
      stall_d     = stall_q;
      bubble_d    = bubble_q;
      if (state_q == ST_RUN) begin
         if (cycle_q != CNT_MAX) cycle_d = cycle_q + CNT_ONE;
         if (w_f_stall && (stall_q != CNT_MAX)) stall_d = stall_q + CNT_ONE;
         if (w_e_bubble && (bubble_q != CNT_MAX)) bubble_d = bubble_q + CNT_ONE;
         if (bus.W_stat != SAOK) begin
            state_d     = ST_HALTED;
            halt_code_d = bus.W_stat;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_RUN;
         halt_code_q <= SAOK;
         cycle_q     <= '0;
         stall_q     <= '0;
         bubble_q    <= '0;
      end else begin
         state_q     <= state_d;
         halt_code_q <= halt_code_d;
         cycle_q     <= cycle_d;
         stall_q     <= stall_d;
         bubble_q    <= bubble_d;
      end
   end

   assign bus.F_stall    = w_f_stall;
   assign bus.D_stall    = w_d_stall;
   assign bus.D_bubble   = w_d_bubble;
   assign bus.E_bubble   = w_e_bubble;
   assign bus.M_bubble   = w_m_bubble;
   assign bus.W_stall    = w_w_stall;
   assign bus.set_cc     = w_set_cc;
   assign bus.halted     = (state_q == ST_HALTED);
   assign bus.halt_code  = halt_code_q;
   assign bus.cycle_cnt  = cycle_q;
   assign bus.stall_cnt  = stall_q;
   assign bus.bubble_cnt = bubble_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Directed bench for pipe_hazard_ctrl, 32-bit and 4-bit
//                counter instances driven with the same stimulus.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0;
   bit   chk_en = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.CNT_W(32)) b32 ();
   pipe_hazard_ctrl_if #(.CNT_W(4))  b4  ();

   pipe_hazard_ctrl #(.CNT_W(32)) u32 (.clk(clk), .rst(rst), .bus(b32));
   pipe_hazard_ctrl #(.CNT_W(4))  u4  (.clk(clk), .rst(rst), .bus(b4));

   assign b4.D_icode = b32.D_icode;
   assign b4.d_srcA  = b32.d_srcA;
   assign b4.d_srcB  = b32.d_srcB;
   assign b4.E_icode = b32.E_icode;
   assign b4.E_dstM  = b32.E_dstM;
   assign b4.e_cnd   = b32.e_cnd;
   assign b4.M_icode = b32.M_icode;
   assign b4.m_stat  = b32.m_stat;
   assign b4.W_stat  = b32.W_stat;

   // Control vector order: {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}
   logic [6:0] ctrl32, ctrl4;
   assign ctrl32 = {b32.F_stall, b32.D_stall, b32.D_bubble, b32.E_bubble,
                    b32.M_bubble, b32.W_stall, b32.set_cc};
   assign ctrl4  = {b4.F_stall, b4.D_stall, b4.D_bubble, b4.E_bubble,
                    b4.M_bubble, b4.W_stall, b4.set_cc};

   // Reference model state
   bit     m_halt = 1'b0;
   int     m_code = 1;
   longint m_cyc  = 0;
   longint m_stl  = 0;
   longint m_bub  = 0;

   function automatic logic [6:0] model_ctrl(input bit in_rst, input bit hlt);
      bit lu, mp, rp, f, ds, db, eb, mb, ws, cc;
      if (in_rst) return 7'b0011100;
      if (hlt)    return 7'b1101110;
      lu = (b32.E_icode == 4'd5 || b32.E_icode == 4'd11) && b32.E_dstM != 4'hF &&
           (b32.E_dstM == b32.d_srcA || b32.E_dstM == b32.d_srcB);
      mp = (b32.E_icode == 4'd7) && !b32.e_cnd;
      rp = (b32.D_icode == 4'd9) || (b32.E_icode == 4'd9) || (b32.M_icode == 4'd9);
      f  = lu || rp;
      ds = lu;
      db = mp || (rp && !lu);
      eb = mp || lu;
      mb = (b32.m_stat != 4'd1) || (b32.W_stat != 4'd1);
      ws = (b32.W_stat != 4'd1);
      cc = (b32.E_icode == 4'd6) && (b32.m_stat == 4'd1) && (b32.W_stat == 4'd1);
      return {f, ds, db, eb, mb, ws, cc};
   endfunction

   function automatic logic [31:0] sat(input longint v, input int w);
      longint mx;
      mx = (longint'(1) << w) - 1;
      return (v > mx) ? mx[31:0] : v[31:0];
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_halt <= 1'b0;
         m_code <= 1;
         m_cyc  <= 0;
         m_stl  <= 0;
         m_bub  <= 0;
      end else if (!m_halt) begin
         logic [6:0] e;
         e = model_ctrl(1'b0, 1'b0);
         m_cyc <= m_cyc + 1;
         if (e[6]) m_stl <= m_stl + 1;
         if (e[3]) m_bub <= m_bub + 1;
         if (b32.W_stat != 4'd1) begin
            m_halt <= 1'b1;
            m_code <= int'(b32.W_stat);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         logic [6:0] e;
         e = model_ctrl(rst, m_halt);
         chk("ctrl32",   32'(ctrl32), 32'(e));
         chk("ctrl4",    32'(ctrl4),  32'(e));
         chk("halted",   32'(b32.halted),    32'(m_halt));
         chk("halted4",  32'(b4.halted),     32'(m_halt));
         chk("hcode",    32'(b32.halt_code), m_code[31:0]);
         chk("cyc32",    b32.cycle_cnt,      sat(m_cyc, 32));
         chk("stl32",    b32.stall_cnt,      sat(m_stl, 32));
         chk("bub32",    b32.bubble_cnt,     sat(m_bub, 32));
         chk("cyc4",     32'(b4.cycle_cnt),  sat(m_cyc, 4));
         chk("stl4",     32'(b4.stall_cnt),  sat(m_stl, 4));
         chk("bub4",     32'(b4.bubble_cnt), sat(m_bub, 4));
      end
   end

   task automatic drive(input logic [3:0] di, input logic [3:0] sa, input logic [3:0] sb,
                        input logic [3:0] ei, input logic [3:0] edm, input logic cnd,
                        input logic [3:0] mi, input logic [3:0] ms, input logic [3:0] ws);
      b32.D_icode = di;  b32.d_srcA = sa;  b32.d_srcB = sb;
      b32.E_icode = ei;  b32.E_dstM = edm; b32.e_cnd  = cnd;
      b32.M_icode = mi;  b32.m_stat = ms;  b32.W_stat = ws;
   endtask

   task automatic idle();
      drive(4'd1, 4'hF, 4'hF, 4'd1, 4'hF, 1'b0, 4'd1, 4'd1, 4'd1);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      #1 rst = 1'b1;
      #1;
      chk_en = 1'b1;
      chk("rst_ctrl",  32'(ctrl32), 32'b0011100);
      chk("rst_hcode", 32'(b32.halt_code), 32'd1);
      repeat (2) step();
      rst = 1'b0;
      chk("cyc_start", b32.cycle_cnt, 32'd0);

      // Load/use on r3
      drive(4'd6, 4'd3, 4'hF, 4'd5, 4'd3, 1'b0, 4'd1, 4'd1, 4'd1);
      #1 chk("lu_ctrl", 32'(ctrl32), 32'b1101000);
      step(); idle();
      #1;
      chk("lu_cyc", b32.cycle_cnt, 32'd1);
      chk("lu_stl", b32.stall_cnt, 32'd1);
      chk("lu_bub", b32.bubble_cnt, 32'd1);

      drive(4'd1, 4'hF, 4'hF, 4'd7, 4'hF, 1'b0, 4'd1, 4'd1, 4'd1);
      #1 chk("mp_ctrl", 32'(ctrl32), 32'b0011000);
      step();
      drive(4'd1, 4'hF, 4'hF, 4'd7, 4'hF, 1'b1, 4'd1, 4'd1, 4'd1);
      #1 chk("taken_ctrl", 32'(ctrl32), 32'b0000000);
      step();

      // RET through D, E, M
      drive(4'd9, 4'hF, 4'hF, 4'd1, 4'hF, 1'b0, 4'd1, 4'd1, 4'd1);
      #1 chk("retD", 32'(ctrl32), 32'b1010000);
      step();
      drive(4'd1, 4'hF, 4'hF, 4'd9, 4'hF, 1'b0, 4'd1, 4'd1, 4'd1);
      #1 chk("retE", 32'(ctrl32), 32'b1010000);
      step();
      drive(4'd1, 4'hF, 4'hF, 4'd1, 4'hF, 1'b0, 4'd9, 4'd1, 4'd1);
      #1 chk("retM", 32'(ctrl32), 32'b1010000);
      step(); idle();
      #1 chk("ret_done", 32'(ctrl32), 32'b0000000);

      drive(4'd9, 4'hF, 4'd3, 4'd11, 4'd3, 1'b0, 4'd1, 4'd1, 4'd1);
      #1 chk("ret_lu", 32'(ctrl32), 32'b1101000);
      step();
      drive(4'd9, 4'hF, 4'hF, 4'd7, 4'hF, 1'b0, 4'd1, 4'd1, 4'd1);
      #1 chk("ret_mp", 32'(ctrl32), 32'b1011000);
      step();
      drive(4'd1, 4'hF, 4'hF, 4'd6, 4'hF, 1'b0, 4'd1, 4'd1, 4'd1);
      #1 chk("setcc", 32'(ctrl32), 32'b0000001);
      step();

      // Bad address travels from Memory to Writeback
      drive(4'd1, 4'hF, 4'hF, 4'd6, 4'hF, 1'b0, 4'd1, 4'd3, 4'd1);
      #1 chk("madr", 32'(ctrl32), 32'b0000100);
      step();
      drive(4'd1, 4'hF, 4'hF, 4'd6, 4'hF, 1'b0, 4'd1, 4'd1, 4'd3);
      #1;
      chk("wadr", 32'(ctrl32), 32'b0000110);
      chk("pre_halt", 32'(b32.halted), 32'd0);
      step(); idle();
      #1;
      chk("halt_flag", 32'(b32.halted), 32'd1);
      chk("halt_code", 32'(b32.halt_code), 32'd3);
      chk("halt_ctrl", 32'(ctrl32), 32'b1101110);
      drive(4'd6, 4'd3, 4'hF, 4'd5, 4'd3, 1'b0, 4'd1, 4'd1, 4'd1);
      step();
      drive(4'd1, 4'hF, 4'hF, 4'd6, 4'hF, 1'b1, 4'd9, 4'd1, 4'd1);
      step();
      #3 rst = 1'b1;
      #1;
      chk("arst_halted", 32'(b32.halted), 32'd0);
      chk("arst_code",   32'(b32.halt_code), 32'd1);
      chk("arst_cyc",    b32.cycle_cnt, 32'd0);
      chk("arst_stl",    b32.stall_cnt, 32'd0);
      chk("arst_ctrl",   32'(ctrl32), 32'b0011100);
      repeat (2) step();
      rst = 1'b0;

      // Continuous load/use saturates the narrow counters
      drive(4'd6, 4'hF, 4'd7, 4'd5, 4'd7, 1'b0, 4'd1, 4'd1, 4'd1);
      repeat (20) step();
      chk("sat_cyc4", 32'(b4.cycle_cnt),  32'd15);
      chk("sat_stl4", 32'(b4.stall_cnt),  32'd15);
      chk("sat_bub4", 32'(b4.bubble_cnt), 32'd15);
      chk("sat_cyc32", b32.cycle_cnt, 32'd20);
      chk("sat_stl32", b32.stall_cnt, 32'd20);

      drive(4'd1, 4'hF, 4'hF, 4'd1, 4'hF, 1'b0, 4'd1, 4'd1, 4'd2);
      step(); idle();
      #1;
      chk("hlt_flag", 32'(b32.halted), 32'd1);
      chk("hlt_code", 32'(b32.halt_code), 32'd2);
      repeat (3) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
